// File: rtl/emergency_preempt_arbiter.sv
// ---------------------------------------------------------------------------
// emergency_preempt_arbiter
//
// Purpose:
//   Sits between the field emergency-vehicle detectors and the traffic light
//   controller. Captures Left/Right preemption requests (level or short
//   pulse), arbitrates them with Right having fixed priority over Left, and
//   drives at most one emergency grant at a time. Each grant is held for a
//   minimum of T_EM cycles after the controller acknowledges it, every grant
//   release is followed by T_CLR all-red clearance cycles, a missing
//   acknowledge times out after T_ACK cycles, and a Right grant that keeps a
//   pending Left waiting for MAX_HOLD cycles is force-released.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   req_left     in   Left emergency request
//   req_right    in   Right emergency request
//   preempt_ack  in   controller confirms the preempted phase for the grant
//   grant_left   out  Left preemption grant (registered)
//   grant_right  out  Right preemption grant (registered)
//   clear_req    out  all-red request, high only during clearance
//   busy         out  arbiter is not idle
//   ack_timeout  out  one-cycle pulse when the acknowledge window expires
//   buzzer       out  only with PREEMPT_BUZZER_EN: high while a grant is
//                     waiting for ack or holding
//
// Configuration macro:
//   PREEMPT_BUZZER_EN  adds the registered buzzer output
// ---------------------------------------------------------------------------
module emergency_preempt_arbiter #(
    parameter int T_EM     = 9,
    parameter int T_CLR    = 3,
    parameter int T_ACK    = 5,
    parameter int MAX_HOLD = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic req_left,
    input  logic req_right,
    input  logic preempt_ack,
    output logic grant_left,
    output logic grant_right,
    output logic clear_req,
    output logic busy,
    output logic ack_timeout
`ifdef PREEMPT_BUZZER_EN
    ,
    output logic buzzer
`endif
);

    localparam int MAX_AB = (T_EM > T_CLR) ? T_EM : T_CLR;
    localparam int MAX_CD = (T_ACK > MAX_HOLD) ? T_ACK : MAX_HOLD;
    localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_T) + 1;

    localparam logic [CW-1:0] EM_LAST   = CW'(T_EM - 1);
    localparam logic [CW-1:0] CLR_LAST  = CW'(T_CLR - 1);
    localparam logic [CW-1:0] ACK_LAST  = CW'(T_ACK - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        HOLD,
        CLEAR
    } state_t;

    typedef enum logic {
        SIDE_LEFT,
        SIDE_RIGHT
    } side_t;

    state_t        state;
    state_t        next_state;
    side_t         side;
    side_t         next_side;
    logic [CW-1:0] cnt;
    logic          pend_left;
    logic          pend_right;
    logic          last_forced;
    logic          next_last_forced;
    logic          timeout_fire;
    logic          take_left;
    logic          take_right;
    logic          any_left;
    logic          any_right;
    logic          own_req;
    logic          next_granting;

    // A request counts if it is on the wire right now or was captured
    // earlier, so one-cycle pulses are never lost.
    assign any_left  = pend_left | req_left;
    assign any_right = pend_right | req_right;

    // State register. The side register remembers which approach owns the
    // current (or most recent) grant, and last_forced remembers that Right
    // was cut short by the starvation guard so Left gets the next turn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            side        <= SIDE_LEFT;
            last_forced <= 1'b0;
        end else begin
            state       <= next_state;
            side        <= next_side;
            last_forced <= next_last_forced;
        end
    end

    // Next-state logic. Right preempting Left is checked before anything
    // else so the Left minimum hold is waived. Leaving CLEAR picks the next
    // grant directly on the last clearance edge, so there is no idle gap
    // between back-to-back grants.
    always_comb begin
        next_state       = state;
        next_side        = side;
        next_last_forced = last_forced;
        timeout_fire     = 1'b0;
        take_left        = 1'b0;
        take_right       = 1'b0;
        own_req          = (side == SIDE_LEFT) ? req_left : req_right;

        case (state)
            IDLE: begin
                if (any_right) begin
                    next_state = WAIT_ACK;
                    next_side  = SIDE_RIGHT;
                    take_right = 1'b1;
                end else if (any_left) begin
                    next_state = WAIT_ACK;
                    next_side  = SIDE_LEFT;
                    take_left  = 1'b1;
                end
            end

            WAIT_ACK: begin
                if (side == SIDE_LEFT && any_right) begin
                    next_state = CLEAR;
                end else if (preempt_ack) begin
                    next_state = HOLD;
                end else if (cnt == ACK_LAST) begin
                    next_state   = CLEAR;
                    timeout_fire = 1'b1;
                end
            end

            HOLD: begin
                if (side == SIDE_LEFT && any_right) begin
                    next_state = CLEAR;
                end else if (side == SIDE_RIGHT && pend_left && cnt >= HOLD_LAST) begin
                    next_state       = CLEAR;
                    next_last_forced = 1'b1;
                end else if (cnt >= EM_LAST && !own_req) begin
                    next_state = CLEAR;
                end
            end

            CLEAR: begin
                if (cnt == CLR_LAST) begin
                    if (last_forced && pend_left) begin
                        next_state = WAIT_ACK;
                        next_side  = SIDE_LEFT;
                        take_left  = 1'b1;
                    end else if (any_right) begin
                        next_state = WAIT_ACK;
                        next_side  = SIDE_RIGHT;
                        take_right = 1'b1;
                    end else if (any_left) begin
                        next_state = WAIT_ACK;
                        next_side  = SIDE_LEFT;
                        take_left  = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase

        if (take_left) begin
            next_last_forced = 1'b0;
        end

        next_granting = (next_state == WAIT_ACK) || (next_state == HOLD);
    end

    // Shared dwell counter. It restarts on every state change and saturates
    // so a long-held request can never wrap it back into a short count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending flags capture requests while the approach is not being
    // served. Granting an approach clears its flag; a preempted Left
    // re-pends naturally once its grant output drops and req_left is
    // still high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_left  <= 1'b0;
            pend_right <= 1'b0;
        end else begin
            if (take_left) begin
                pend_left <= 1'b0;
            end else if (req_left && !grant_left) begin
                pend_left <= 1'b1;
            end

            if (take_right) begin
                pend_right <= 1'b0;
            end else if (req_right && !grant_right) begin
                pend_right <= 1'b1;
            end
        end
    end

    // Outputs are registered from the next state, so a grant appears on the
    // same edge that commits the decision. Grants are only ever driven in
    // WAIT_ACK/HOLD and clear_req only in CLEAR, which keeps them mutually
    // exclusive by construction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_left  <= 1'b0;
            grant_right <= 1'b0;
            clear_req   <= 1'b0;
            busy        <= 1'b0;
            ack_timeout <= 1'b0;
        end else begin
            grant_left  <= next_granting && (next_side == SIDE_LEFT);
            grant_right <= next_granting && (next_side == SIDE_RIGHT);
            clear_req   <= (next_state == CLEAR);
            busy        <= (next_state != IDLE);
            ack_timeout <= timeout_fire;
        end
    end

`ifdef PREEMPT_BUZZER_EN
    // Audible warning follows the grant phases, registered like every
    // other output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buzzer <= 1'b0;
        end else begin
            buzzer <= next_granting;
        end
    end
`endif

endmodule
